// File: rtl/mine_drop_object_pkg.sv
`default_nettype none
// mine_pkg: shared state encoding, default sizes and frame-count constants
// for the falling-mine sprite generator.
package mine_pkg;

  localparam int COORD_W = 11;

  localparam int DEF_OBJECT_WIDTH   = 32;
  localparam int DEF_OBJECT_HEIGHT  = 32;
  localparam int DEF_GRAVITY        = 1;
  localparam int DEF_MAX_SPEED      = 8;
  localparam int DEF_EXPLODE_FRAMES = 30;
  localparam int DEF_LANDED_FRAMES  = 120;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FALLING   = 2'd1,
    LANDED    = 2'd2,
    EXPLODING = 2'd3
  } mine_state_t;

  // Frame counter width: wide enough for both timers, and at least 3 bits
  // so the blink phase bit always exists.
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mine_drop_object_rect_bracket.sv
`default_nettype none
// rect_bracket: registered point-in-rectangle test with per-pixel offsets,
// reusable by any sprite that knows its top-left corner.
module rect_bracket #(
  parameter int COORD_W = 11,
  parameter int WIDTH   = 32,
  parameter int HEIGHT  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] i_pixelX,
  input  logic [COORD_W-1:0] i_pixelY,
  input  logic [COORD_W-1:0] i_topLeftX,
  input  logic [COORD_W-1:0] i_topLeftY,
  input  logic               i_enable,
  output logic [COORD_W-1:0] o_offsetX,
  output logic [COORD_W-1:0] o_offsetY,
  output logic               o_inside
);

  localparam logic [COORD_W:0] W_EXT = WIDTH[COORD_W:0];
  localparam logic [COORD_W:0] H_EXT = HEIGHT[COORD_W:0];

  logic [COORD_W:0]   w_px;
  logic [COORD_W:0]   w_py;
  logic [COORD_W:0]   w_left;
  logic [COORD_W:0]   w_top;
  logic               w_inside;
  logic [COORD_W-1:0] w_dx;
  logic [COORD_W-1:0] w_dy;

  // One extra bit so a sprite touching the right/bottom screen edge never wraps.
  always_comb begin
    w_px     = {1'b0, i_pixelX};
    w_py     = {1'b0, i_pixelY};
    w_left   = {1'b0, i_topLeftX};
    w_top    = {1'b0, i_topLeftY};
    w_inside = i_enable
             && (w_px >= w_left) && (w_px < (w_left + W_EXT))
             && (w_py >= w_top)  && (w_py < (w_top + H_EXT));
    w_dx     = i_pixelX - i_topLeftX;
    w_dy     = i_pixelY - i_topLeftY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_inside  <= 1'b0;
      o_offsetX <= '0;
      o_offsetY <= '0;
    end else begin
      o_inside  <= w_inside;
      o_offsetX <= w_inside ? w_dx : '0;
      o_offsetY <= w_inside ? w_dy : '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mine_drop_object.sv
`default_nettype none
// mine_drop_object: drop/fall/land/explode motion generator for a mine sprite.
// Define MINE_EXPLODE_BLINK_EN to blink the sprite (4 on / 4 off) while exploding.
module mine_drop_object
  import mine_pkg::*;
#(
  parameter int OBJECT_WIDTH   = DEF_OBJECT_WIDTH,
  parameter int OBJECT_HEIGHT  = DEF_OBJECT_HEIGHT,
  parameter int GRAVITY        = DEF_GRAVITY,
  parameter int MAX_SPEED      = DEF_MAX_SPEED,
  parameter int EXPLODE_FRAMES = DEF_EXPLODE_FRAMES,
  parameter int LANDED_FRAMES  = DEF_LANDED_FRAMES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic               dropReq,
  input  logic [COORD_W-1:0] dropX,
  input  logic [COORD_W-1:0] floorY,
  input  logic               hitDetected,
  output logic [COORD_W-1:0] offsetX,
  output logic [COORD_W-1:0] offsetY,
  output logic               objectExists,
  output logic               mineActive,
  output logic               explodeDone
);

  localparam int CNT_W          = cnt_width(EXPLODE_FRAMES, LANDED_FRAMES);
  localparam int LAND_LAST_I    = LANDED_FRAMES - 1;
  localparam int EXPL_LAST_I    = EXPLODE_FRAMES - 1;
  localparam logic [CNT_W-1:0] LAND_LAST = LAND_LAST_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] EXPL_LAST = EXPL_LAST_I[CNT_W-1:0];
  localparam logic [COORD_W:0]   H_EXT    = OBJECT_HEIGHT[COORD_W:0];
  localparam logic [COORD_W-1:0] H_NARROW = OBJECT_HEIGHT[COORD_W-1:0];
  localparam logic [COORD_W:0]   GRAV_EXT = GRAVITY[COORD_W:0];
  localparam logic [COORD_W:0]   MAXS_EXT = MAX_SPEED[COORD_W:0];

  mine_state_t        r_state;
  mine_state_t        w_state_next;
  logic [COORD_W-1:0] r_topLeftX;
  logic [COORD_W-1:0] w_topLeftX_next;
  logic [COORD_W-1:0] r_topLeftY;
  logic [COORD_W-1:0] w_topLeftY_next;
  logic [COORD_W-1:0] r_speed;
  logic [COORD_W-1:0] w_speed_next;
  logic [CNT_W-1:0]   r_frameCnt;
  logic [CNT_W-1:0]   w_frameCnt_next;
  logic               r_mineActive;
  logic               r_explodeDone;
  logic               w_explodeDone_next;

  logic [COORD_W:0]   w_nextY;
  logic [COORD_W:0]   w_bottom;
  logic [COORD_W:0]   w_speedSum;
  logic [COORD_W-1:0] w_speedInc;
  logic [COORD_W-1:0] w_landY;
  logic               w_blank;
  logic               w_drawEn;
  logic               w_inside;

  always_comb begin
    w_nextY    = {1'b0, r_topLeftY} + {1'b0, r_speed};
    w_bottom   = w_nextY + H_EXT;
    w_speedSum = {1'b0, r_speed} + GRAV_EXT;
    w_speedInc = (w_speedSum >= MAXS_EXT) ? MAXS_EXT[COORD_W-1:0]
                                          : w_speedSum[COORD_W-1:0];
    w_landY    = (floorY < H_NARROW) ? '0 : (floorY - H_NARROW);
  end

  always_comb begin
    w_state_next       = r_state;
    w_topLeftX_next    = r_topLeftX;
    w_topLeftY_next    = r_topLeftY;
    w_speed_next       = r_speed;
    w_frameCnt_next    = r_frameCnt;
    w_explodeDone_next = 1'b0;

    case (r_state)
      IDLE: begin
        if (dropReq) begin
          w_state_next    = FALLING;
          w_topLeftX_next = dropX;
          w_topLeftY_next = '0;
          w_speed_next    = '0;
          w_frameCnt_next = '0;
        end
      end
      FALLING: begin
        // A hit suppresses the position update of a coincident frame.
        if (hitDetected) begin
          w_state_next    = EXPLODING;
          w_frameCnt_next = '0;
        end else if (startOfFrame) begin
          w_speed_next = w_speedInc;
          if (w_bottom >= {1'b0, floorY}) begin
            w_topLeftY_next = w_landY;
            w_state_next    = LANDED;
            w_frameCnt_next = '0;
          end else begin
            w_topLeftY_next = w_nextY[COORD_W-1:0];
          end
        end
      end
      LANDED: begin
        if (hitDetected) begin
          w_state_next    = EXPLODING;
          w_frameCnt_next = '0;
        end else if (startOfFrame) begin
          if (r_frameCnt == LAND_LAST) begin
            w_state_next    = EXPLODING;
            w_frameCnt_next = '0;
          end else begin
            w_frameCnt_next = r_frameCnt + 1'b1;
          end
        end
      end
      EXPLODING: begin
        if (startOfFrame) begin
          if (r_frameCnt == EXPL_LAST) begin
            w_state_next       = IDLE;
            w_frameCnt_next    = '0;
            w_explodeDone_next = 1'b1;
          end else begin
            w_frameCnt_next = r_frameCnt + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_topLeftX    <= '0;
      r_topLeftY    <= '0;
      r_speed       <= '0;
      r_frameCnt    <= '0;
      r_mineActive  <= 1'b0;
      r_explodeDone <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_topLeftX    <= w_topLeftX_next;
      r_topLeftY    <= w_topLeftY_next;
      r_speed       <= w_speed_next;
      r_frameCnt    <= w_frameCnt_next;
      r_mineActive  <= (w_state_next != IDLE);
      r_explodeDone <= w_explodeDone_next;
    end
  end

`ifdef MINE_EXPLODE_BLINK_EN
  assign w_blank = (r_state == EXPLODING) && r_frameCnt[2];
`else
  assign w_blank = 1'b0;
`endif

  assign w_drawEn = (r_state != IDLE) && !w_blank;

  rect_bracket #(
    .COORD_W (COORD_W),
    .WIDTH   (OBJECT_WIDTH),
    .HEIGHT  (OBJECT_HEIGHT)
  ) u_bracket (
    .clk        (clk),
    .rst        (reset),
    .i_pixelX   (pixelX),
    .i_pixelY   (pixelY),
    .i_topLeftX (r_topLeftX),
    .i_topLeftY (r_topLeftY),
    .i_enable   (w_drawEn),
    .o_offsetX  (offsetX),
    .o_offsetY  (offsetY),
    .o_inside   (w_inside)
  );

  assign objectExists = w_inside;
  assign mineActive   = r_mineActive;
  assign explodeDone  = r_explodeDone;

endmodule
`default_nettype wire
